// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e : fetch control states (idle after reset, running, draining stale responses)
//   InstrWidth  : instruction / address width
//   PcIncr      : sequential fetch address step
package instr_fetch_unit_pkg;

    localparam int unsigned InstrWidth = 32;
    localparam logic [31:0] PcIncr     = 32'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetch buffer: small circular FIFO holding {pc, instr} pairs for decode.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_push, i_data      : write request and data (accepted when not full, or when popping)
//   i_pop               : remove head entry (ignored when empty)
//   i_flush             : drop all entries; wins over push and pop
//   o_data              : head entry
//   o_full, o_empty     : occupancy flags
//   o_count             : number of stored entries
module ifu_fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2 * InstrWidth
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_flush,
    input  logic [WIDTH-1:0]               i_data,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH + 1)-1:0]   o_count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign o_full    = (r_count == CntW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full buffer still takes a write when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CntW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches to instruction memory, buffers in-order
// responses with their addresses and streams them to decode. Redirects (j_br) flush the
// buffer and discard responses still in flight.
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- a redirect to a non word-aligned target
// sets the sticky if_misalign flag and parks the unit in idle. Without it the target's low
// two bits are cleared and if_misalign stays 0.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   j_br, bta                         : redirect request and target
//   imem_req, imem_addr, imem_gnt     : request handshake to instruction memory
//   imem_rvalid, imem_rdata           : in-order memory responses
//   if_valid, if_instr, if_pc, if_ready : instruction stream to decode
//   if_misalign                       : sticky misaligned-target flag
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        j_br,
    input  logic [31:0] bta,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        if_misalign
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    ifu_state_e                  r_state;
    logic [31:0]                 r_fetch_pc;
    logic [31:0]                 r_resp_pc;      // address of the oldest live in-flight request
    logic [CntW-1:0]             r_outstanding;  // all in-flight requests, stale or not
    logic [CntW-1:0]             r_discard;      // oldest in-flight requests to throw away
    logic                        r_misalign;

    logic [CntW-1:0]             w_fifo_count;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [2*InstrWidth-1:0]     w_fifo_rdata;
    logic [CntW:0]               w_occupancy;
    logic                        w_req;
    logic                        w_gnt_acc;
    logic                        w_rsp_acc;
    logic                        w_rsp_stale;
    logic                        w_push;
    logic                        w_pop;
    logic [CntW-1:0]             w_inflight_next;
    logic [31:0]                 w_bta;
    logic                        w_bad_target;

`ifdef IFU_MISALIGN_CHECK_EN
    assign w_bta        = bta;
    assign w_bad_target = j_br & (bta[1:0] != 2'b00);
`else
    assign w_bta        = bta & 32'hFFFF_FFFC;
    assign w_bad_target = 1'b0;
`endif

    // Requests in flight plus buffered entries never exceed the buffer depth, so every
    // response always has a slot.
    assign w_occupancy     = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign w_req           = (r_state == StRun) & ~w_fifo_full &
                             (w_occupancy < (CntW + 1)'(FIFO_DEPTH));
    assign w_gnt_acc       = w_req & imem_gnt;
    assign w_rsp_acc       = imem_rvalid & (r_outstanding != '0);
    assign w_rsp_stale     = w_rsp_acc & (r_discard != '0);
    assign w_push          = w_rsp_acc & ~w_rsp_stale & ~j_br;
    assign w_pop           = if_valid & if_ready & ~j_br;
    assign w_inflight_next = r_outstanding + CntW'(w_gnt_acc) - CntW'(w_rsp_acc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_misalign    <= 1'b0;
        end else begin
            r_outstanding <= w_inflight_next;
            if (j_br) begin
                r_fetch_pc <= w_bta;
                r_resp_pc  <= w_bta;
                // Everything still in flight after this edge (incl. a same-cycle grant) is stale.
                r_discard  <= w_inflight_next;
                if (w_bad_target) begin
                    r_misalign <= 1'b1;
                    r_state    <= StIdle;
                end else if (r_misalign) begin
                    r_state <= StIdle;
                end else if (w_inflight_next != '0) begin
                    r_state <= StDrain;
                end else begin
                    r_state <= StRun;
                end
            end else begin
                if (w_gnt_acc) begin
                    r_fetch_pc <= r_fetch_pc + PcIncr;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + PcIncr;
                end
                if (w_rsp_stale) begin
                    r_discard <= r_discard - CntW'(1);
                end
                case (r_state)
                    StIdle:  if (!r_misalign) r_state <= StRun;
                    StDrain: if (w_rsp_stale && r_discard == CntW'(1)) r_state <= StRun;
                    default: ;
                endcase
            end
        end
    end

    ifu_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * InstrWidth)
    ) u_fetch_fifo (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (j_br),
        .i_data  ({r_resp_pc, imem_rdata}),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign imem_req           = w_req;
    assign imem_addr          = r_fetch_pc;
    assign if_valid           = ~w_fifo_empty;
    assign {if_pc, if_instr}  = w_fifo_rdata;
    assign if_misalign        = r_misalign;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: fetch buffer entries, which is also the outstanding-request cap.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port j_br, input, 1: redirect request (jump or taken branch).
REQ-006 SHALL have port bta, input, 32: redirect target, sampled when j_br=1.
REQ-007 SHALL have ports imem_req (output, 1), imem_addr (output, 32) and imem_gnt (input, 1): request handshake to instruction memory.
REQ-008 SHALL have ports imem_rvalid (input, 1) and imem_rdata (input, 32): in-order memory responses.
REQ-009 SHALL have ports if_valid (output, 1), if_instr (output, 32), if_pc (output, 32) and if_ready (input, 1): instruction stream to decode.
REQ-010 SHALL have port if_misalign, output, 1: sticky misaligned-target flag.

Function
REQ-011 SHALL track fetch_pc; a request is accepted on imem_req & imem_gnt, after which fetch_pc += 4, wrapping modulo 2^32.
REQ-012 SHALL assert imem_req only while in RUN and (outstanding + buffered) < FIFO_DEPTH.
REQ-013 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0; the only exception is a redirect, which may withdraw the request.
REQ-014 SHALL write each accepted response (rdata plus its request address) into the FIFO; if_valid SHALL rise the cycle after imem_rvalid, never combinationally.
REQ-015 SHALL pop the FIFO head on if_valid & if_ready; if_instr and if_pc SHALL hold while if_ready=0.
REQ-016 SHALL support simultaneous push and pop at full occupancy with no loss and no stall bubble.
REQ-017 SHALL implement states IDLE, RUN and DRAIN:
- IDLE->RUN: the first cycle after reset release.
- RUN->DRAIN: j_br=1 with outstanding>0.
- RUN->RUN: j_br=1 with outstanding=0, fetch_pc=bta.
- DRAIN->RUN: the final stale imem_rvalid arrives.
REQ-018 On j_br SHALL flush the FIFO in the same cycle and deassert if_valid the next cycle; fetch_pc SHALL become bta.
REQ-019 On j_br, stale responses SHALL be counted and discarded; no request SHALL issue in DRAIN.
REQ-020 A redirect arriving in DRAIN SHALL update fetch_pc to the newest bta and keep the discard count.
REQ-021 j_br coinciding with imem_gnt SHALL count that request as stale.
REQ-022 j_br SHALL win over a simultaneous pop or push.
REQ-023 imem_rvalid with zero outstanding SHALL be ignored.

Reset
REQ-024 While reset_n=0 SHALL hold: state=IDLE, fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_misalign=0.
REQ-025 Reset mid-transaction SHALL abandon all in-flight requests; late responses SHALL be ignored per REQ-023.

Configuration
REQ-026 With macro IFU_MISALIGN_CHECK_EN defined:
- A redirect with bta[1:0]!=0 SHALL set if_misalign and enter IDLE, issuing nothing.
- Only reset SHALL clear if_misalign.
REQ-027 Without IFU_MISALIGN_CHECK_EN:
- bta[1:0] SHALL be forced to 2'b00.
- if_misalign SHALL be tied 0.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN), the instruction width of 32 and the PC increment of 4.
REQ-029 The FIFO SHALL be a sub-module named ifu_fetch_fifo with push, pop, flush, full, empty and count signals.

Verification
REQ-030 Reset release with imem_gnt=1 and 1-cycle rvalid SHALL produce addrs 0,4,8; instrs SHALL appear on if_valid in order, each one cycle after its rvalid.
REQ-031 With if_ready=0 and 2 responses, imem_req SHALL drop when full; on release, pops SHALL resume with no duplicate or lost instruction.
REQ-032 j_br=1, bta=0x100 with 2 outstanding SHALL discard both responses; the next imem_addr SHALL be 0x100, and if_pc 0x100 SHALL be the first delivered.
REQ-033 Holding imem_gnt=0 for 5 cycles SHALL keep imem_addr stable; fetch_pc SHALL advance only on gnt.
REQ-034 fetch_pc=0xFFFF_FFFC SHALL issue that addr and then 0x0000_0000.
REQ-035 bta=0x102: with IFU_MISALIGN_CHECK_EN, if_misalign SHALL be 1 with no further imem_req; without it, the fetch SHALL go to 0x100.
